// File: rtl/lc3_regfile_pkg.sv
// Shared types for the LC3 register file: clear-sequencer states, NZP codes
// and the nzp() helper that classifies a value as negative, zero or positive.
package lc3_rf_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_e;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    // Widest register supported by nzp(); callers sign-extend into this width.
    localparam int NZP_W = 64;

    function automatic logic [2:0] nzp(input logic signed [NZP_W-1:0] value);
        logic [2:0] code;
        if (value[NZP_W-1]) begin
            code = CC_N;
        end else if (value == {NZP_W{1'b0}}) begin
            code = CC_Z;
        end else begin
            code = CC_P;
        end
        return code;
    endfunction

endpackage

// File: rtl/lc3_regfile_clear_seq.sv
// Clear sequencer: walks every register entry once after reset or a clear
// request, emitting one zero-write per cycle while busy is high.
module rf_clear_seq
    import lc3_rf_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    rf_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Next-state and counter update; requests during a sweep are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RF_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        busy_d = (state_d == RF_CLEAR);
    end

    // State, counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = busy_q;
    assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/lc3_regfile.sv
// LC3 general-purpose register file: 2 async reads, 1 sync write, NZP register
// and a self-clearing sweep. Optional write-to-read bypass: LC3_REGFILE_BYPASS_EN.
module lc3_regfile
    import lc3_rf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              cc_we,
    output logic [2:0]        cc,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [2:0]        cc_q, cc_d;

    logic              busy_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              clr_start_s;
    logic              user_we_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // A clear request in IDLE takes the same edge as any user write, so it wins.
    assign clr_start_s = clr_req & ~busy_s;
    assign user_we_s   = we & ~busy_s & ~clr_req;

    // Write-port arbitration between the clear sweep and the writeback stage.
    always_comb begin
        if (clr_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_addr_s;
            wr_data_s = {DATA_W{1'b0}};
        end else begin
            wr_en_s   = user_we_s;
            wr_addr_s = wa;
            wr_data_s = wd;
        end
    end

    // Register array; contents are only defined once a sweep has completed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Read ports, zeroed while the sweep runs.
    always_comb begin
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
`ifdef LC3_REGFILE_BYPASS_EN
        if (user_we_s && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = mem_q[ra1];
        end
        if (user_we_s && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = mem_q[ra2];
        end
`else
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
`endif
        if (busy_s) begin
            rd1 = {DATA_W{1'b0}};
            rd2 = {DATA_W{1'b0}};
        end else begin
            rd1 = rd1;
            rd2 = rd2;
        end
    end

    // Condition codes: reload Z on sweep start, else follow accepted writes.
    always_comb begin
        cc_d = cc_q;
        if (clr_start_s) begin
            cc_d = CC_Z;
        end else if (user_we_s && cc_we) begin
            cc_d = nzp(NZP_W'($signed(wd)));
        end else begin
            cc_d = cc_q;
        end
    end

    // Condition-code register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= CC_Z;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc   = cc_q;
    assign busy = busy_s;

endmodule

// File: tb/tb_lc3_regfile.sv
// Directed self-checking bench for lc3_regfile: default 16x8 instance and a
// 32x16 instance. Expectations follow LC3_REGFILE_BYPASS_EN when defined.
module tb_lc3_regfile;

`ifdef LC3_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clr_req, we, cc_we;
    logic [2:0]  ra1, ra2, wa;
    logic [15:0] wd, rd1, rd2;
    logic [2:0]  cc;
    logic        busy;

    logic        rst_b, clr_req_b, we_b, cc_we_b;
    logic [3:0]  ra1_b, ra2_b, wa_b;
    logic [31:0] wd_b, rd1_b, rd2_b;
    logic [2:0]  cc_b;
    logic        busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_regfile #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .we(we), .wa(wa), .wd(wd), .cc_we(cc_we),
        .cc(cc), .busy(busy)
    );

    lc3_regfile #(.DATA_W(32), .ADDR_W(4)) dut_w (
        .clk(clk), .rst(rst_b), .clr_req(clr_req_b), .ra1(ra1_b), .ra2(ra2_b),
        .rd1(rd1_b), .rd2(rd2_b), .we(we_b), .wa(wa_b), .wd(wd_b), .cc_we(cc_we_b),
        .cc(cc_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic c);
        we = 1'b1; wa = a; wd = d; cc_we = c;
        step();
        we = 1'b0; cc_we = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; clr_req = 1'b0; we = 1'b0; cc_we = 1'b0;
        ra1 = 3'd0; ra2 = 3'd0; wa = 3'd0; wd = 16'h0000;
        rst_b = 1'b0; clr_req_b = 1'b0; we_b = 1'b0; cc_we_b = 1'b0;
        ra1_b = 4'd0; ra2_b = 4'd0; wa_b = 4'd0; wd_b = 32'h0;

        // Reset and initial sweep
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cc", 32'(cc), 32'h2);
        chk("rst_rd1", 32'(rd1), 32'h0);
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("rst_clr_len", n, 32'd8);
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i);
            #1;
            chk("swept_rd1", 32'(rd1), 32'h0);
            chk("swept_rd2", 32'(rd2), 32'h0);
        end

        // Write R3 negative with cc update; bypass visibility before edge
        ra1 = 3'd3;
        we = 1'b1; wa = 3'd3; wd = 16'h8001; cc_we = 1'b1;
        #1;
        chk("r3_pre_edge", 32'(rd1), BYP ? 32'h8001 : 32'h0);
        step();
        we = 1'b0; cc_we = 1'b0;
        #1;
        chk("r3_rd1", 32'(rd1), 32'h8001);
        chk("cc_neg", 32'(cc), 32'h4);

        wr(3'd5, 16'h0000, 1'b1);
        chk("cc_zero", 32'(cc), 32'h2);
        wr(3'd6, 16'h0005, 1'b0);
        chk("cc_hold", 32'(cc), 32'h2);
        wr(3'd7, 16'h7FFF, 1'b1);
        chk("cc_pos", 32'(cc), 32'h1);
        wr(3'd0, 16'hA5A5, 1'b0);
        chk("cc_hold_p", 32'(cc), 32'h1);
        ra1 = 3'd0; ra2 = 3'd6;
        #1;
        chk("r0_rd1", 32'(rd1), 32'hA5A5);
        chk("r6_rd2", 32'(rd2), 32'h0005);

        // Same-address read/write on both ports
        ra1 = 3'd2; ra2 = 3'd2;
        we = 1'b1; wa = 3'd2; wd = 16'h1234; cc_we = 1'b0;
        #1;
        chk("byp_rd1", 32'(rd1), BYP ? 32'h1234 : 32'h0);
        chk("byp_rd2", 32'(rd2), BYP ? 32'h1234 : 32'h0);
        step();
        we = 1'b0;
        #1;
        chk("r2_rd1", 32'(rd1), 32'h1234);
        chk("r2_rd2", 32'(rd2), 32'h1234);

        // Clear request collides with a write
        ra1 = 3'd1; ra2 = 3'd3;
        clr_req = 1'b1; we = 1'b1; wa = 3'd1; wd = 16'hBEEF; cc_we = 1'b1;
        #1;
        chk("clr_pre_busy", 32'(busy), 32'd0);
        step();
        clr_req = 1'b0; we = 1'b0; cc_we = 1'b0;
        #1;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_forced_rd2", 32'(rd2), 32'h0);
        chk("clr_cc", 32'(cc), 32'h2);
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("clr_len", n, 32'd8);
        #1;
        chk("r1_dropped", 32'(rd1), 32'h0);
        chk("r3_cleared", 32'(rd2), 32'h0);
        chk("clr_cc_after", 32'(cc), 32'h2);

        // Reset in the middle of a sweep; writes and requests while busy
        wr(3'd4, 16'h8000, 1'b1);
        chk("cc_neg2", 32'(cc), 32'h4);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1; we = 1'b1; wa = 3'd4; wd = 16'h7FFF; cc_we = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            clr_req = (n < 3);
            step();
            n++;
        end
        clr_req = 1'b0; we = 1'b0; cc_we = 1'b0;
        chk("mid_rst_len", n, 32'd8);
        ra1 = 3'd4;
        #1;
        chk("mid_rst_cc", 32'(cc), 32'h2);
        chk("mid_rst_r4", 32'(rd1), 32'h0);

        // Wide instance: 32-bit data, 16 entries
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        n = 0;
        while (busy_b && n < 60) begin step(); n++; end
        chk("w_rst_len", n, 32'd16);
        chk("w_cc_rst", 32'(cc_b), 32'h2);
        we_b = 1'b1; wa_b = 4'd15; wd_b = 32'hFFFFFFFF; cc_we_b = 1'b1; ra1_b = 4'd15;
        step();
        we_b = 1'b0; cc_we_b = 1'b0;
        #1;
        chk("w_r15", rd1_b, 32'hFFFFFFFF);
        chk("w_cc_neg", 32'(cc_b), 32'h4);
        clr_req_b = 1'b1;
        step();
        clr_req_b = 1'b0;
        chk("w_cc_clr", 32'(cc_b), 32'h2);
        n = 0;
        while (busy_b && n < 60) begin step(); n++; end
        chk("w_clr_len", n, 32'd16);
        #1;
        chk("w_r15_cleared", rd1_b, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
